// File: rtl/cmi_proto_pkg.sv
// ---------------------------------------------------------------------------
// cmi_proto_pkg
// Shared definitions for the CMI link slave endpoint: sync bytes, frame
// lengths, marker type codes, RX/TX state encodings, the latched answer
// packet and a helper that serialises that packet byte by byte.
// ---------------------------------------------------------------------------
package cmi_proto_pkg;

  localparam logic [7:0] SYNC_PKT = 8'hA5;
  localparam logic [7:0] SYNC_MRK = 8'h5A;
  localparam int         PKT_LEN  = 11;  // A5, HEAD, 8 data bytes, CHK
  localparam int         MRK_LEN  = 3;   // 5A, M, ~M
  localparam int         PKT_DATA_BYTES = 8;

  typedef enum logic [1:0] {
    MRK_BROADCAST = 2'b00,
    MRK_SLOT1     = 2'b01,
    MRK_SLOT2     = 2'b10,
    MRK_RESEND    = 2'b11
  } marker_type_e;

  typedef enum logic [2:0] {
    R_IDLE = 3'd0,
    R_PHDR = 3'd1,
    R_PDAT = 3'd2,
    R_PCHK = 3'd3,
    R_MB   = 3'd4,
    R_MCHK = 3'd5
  } rx_state_e;

  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_GUARD = 3'd1,
    T_LOAD  = 3'd2,
    T_ACK   = 3'd3,
    T_DONE  = 3'd4
  } tx_state_e;

  // Answer packet contents captured when an own-slot marker is accepted.
  typedef struct packed {
    logic [7:0]  head;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] d3;
  } pkt_s;

  // Byte idx of an outgoing packet; words go out big-endian, byte 10 is the
  // running checksum supplied by the caller.
  function automatic logic [7:0] pkt_byte(input pkt_s p, input logic [3:0] idx,
                                          input logic [7:0] chk);
    case (idx)
      4'd0:    return SYNC_PKT;
      4'd1:    return p.head;
      4'd2:    return p.d0[15:8];
      4'd3:    return p.d0[7:0];
      4'd4:    return p.d1[15:8];
      4'd5:    return p.d1[7:0];
      4'd6:    return p.d2[15:8];
      4'd7:    return p.d2[7:0];
      4'd8:    return p.d3[15:8];
      4'd9:    return p.d3[7:0];
      4'd10:   return chk;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/cmi_frame_parser.sv
// ---------------------------------------------------------------------------
// cmi_frame_parser
// Receive side of the CMI link. Decodes data packets (A5,HEAD,8 data,CHK)
// and marker frames (5A,M,~M) from the byte stream, with an inter-byte
// timeout that aborts a stalled frame.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   rx_ena, rx_data          1-clk byte strobe and byte from the UART core
//   marker_st, marker_type   pulse per valid marker, held marker type
//   rx_head, rx_data0..3     held contents of the last good packet
//   rx_st                    pulse: good packet, held outputs updated
//   rx_fault                 pulse: checksum error, bad marker or timeout
// ---------------------------------------------------------------------------
module cmi_frame_parser
  import cmi_proto_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_ena,
  input  logic [7:0]  rx_data,
  output logic        marker_st,
  output logic [1:0]  marker_type,
  output logic [7:0]  rx_head,
  output logic [15:0] rx_data0,
  output logic [15:0] rx_data1,
  output logic [15:0] rx_data2,
  output logic [15:0] rx_data3,
  output logic        rx_st,
  output logic        rx_fault
);

  localparam int TW = $clog2(BYTE_TIMEOUT + 1);

  rx_state_e   state;
  logic [2:0]  cnt;       // data byte index inside R_PDAT
  logic [63:0] shift;     // data bytes, first received ends up in [63:56]
  logic [7:0]  head_q;
  logic [7:0]  acc;       // running XOR of HEAD..D3l
  logic [7:0]  mark_q;
  logic [TW-1:0] tmo;

  // NOTE: the shift/holding registers are reset as well, so a reset leaves
  // every output at 0 rather than at stale data from an aborted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= R_IDLE;
      cnt         <= '0;
      shift       <= '0;
      head_q      <= '0;
      acc         <= '0;
      mark_q      <= '0;
      tmo         <= '0;
      marker_st   <= 1'b0;
      marker_type <= 2'b00;
      rx_head     <= '0;
      rx_data0    <= '0;
      rx_data1    <= '0;
      rx_data2    <= '0;
      rx_data3    <= '0;
      rx_st       <= 1'b0;
      rx_fault    <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere; the pulse defaults below are simply
      // overridden later in the block when a frame completes this edge.
      marker_st <= 1'b0;
      rx_st     <= 1'b0;
      rx_fault  <= 1'b0;

      if (rx_ena) begin
        tmo <= '0;
        case (state)
          R_IDLE: begin
            if (rx_data == SYNC_PKT)      state <= R_PHDR;
            else if (rx_data == SYNC_MRK) state <= R_MB;
          end
          R_PHDR: begin
            head_q <= rx_data;
            acc    <= rx_data;
            cnt    <= '0;
            state  <= R_PDAT;
          end
          R_PDAT: begin
            // Sync values are ordinary data once inside a frame.
            shift <= {shift[55:0], rx_data};
            acc   <= acc ^ rx_data;
            if (cnt == 3'(PKT_DATA_BYTES - 1)) state <= R_PCHK;
            else                              cnt   <= cnt + 3'd1;
          end
          R_PCHK: begin
            if (rx_data == acc) begin
              rx_st    <= 1'b1;
              rx_head  <= head_q;
              rx_data0 <= shift[63:48];
              rx_data1 <= shift[47:32];
              rx_data2 <= shift[31:16];
              rx_data3 <= shift[15:0];
            end else begin
              rx_fault <= 1'b1;
            end
            state <= R_IDLE;
          end
          R_MB: begin
            mark_q <= rx_data;
            state  <= R_MCHK;
          end
          R_MCHK: begin
            // M carries only a 2-bit type; anything in the upper bits or a
            // wrong complement is a corrupted marker.
            if (mark_q[7:2] == 6'd0 && rx_data == ~mark_q) begin
              marker_st   <= 1'b1;
              marker_type <= mark_q[1:0];
            end else begin
              rx_fault <= 1'b1;
            end
            state <= R_IDLE;
          end
          default: state <= R_IDLE;
        endcase
      end else if (state != R_IDLE) begin
        if (tmo == TW'(BYTE_TIMEOUT - 1)) begin
          rx_fault <= 1'b1;
          tmo      <= '0;
          state    <= R_IDLE;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cmi_slot_responder.sv
// ---------------------------------------------------------------------------
// cmi_slot_responder
// Slave endpoint of the CMI link. The frame parser decodes the master's byte
// stream; when a marker for this node's slot arrives and the transmitter is
// idle, the local words are latched and, after a guard time, sent back as
// one 11-byte data packet through the UART byte core handshake.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   enable                   1 = answer own-slot markers
//   rx_ena, rx_data          received byte strobe and value
//   tx_busy                  byte core busy
//   tx_data, tx_enable       byte to send and its 1-clk launch strobe
//   data0..3_self            local words sampled at marker accept
//   marker_st, marker_type   marker pulse / held type
//   rx_head, rx_data0..3     held last good packet
//   rx_st, rx_fault          good packet / receive error pulses
//   slot_overrun             own marker dropped because TX was busy
//   tx_active                high from marker accept until the last byte
// ---------------------------------------------------------------------------
module cmi_slot_responder
  import cmi_proto_pkg::*;
#(
  parameter logic [1:0] SLOT_ID      = 2'b01,
  parameter int         GUARD_CLKS   = 16,
  parameter int         BYTE_TIMEOUT = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        rx_ena,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_enable,
  input  logic [15:0] data0_self,
  input  logic [15:0] data1_self,
  input  logic [15:0] data2_self,
  input  logic [15:0] data3_self,
  output logic        marker_st,
  output logic [1:0]  marker_type,
  output logic [7:0]  rx_head,
  output logic [15:0] rx_data0,
  output logic [15:0] rx_data1,
  output logic [15:0] rx_data2,
  output logic [15:0] rx_data3,
  output logic        rx_st,
  output logic        rx_fault,
  output logic        slot_overrun,
  output logic        tx_active
);

  localparam int GW = (GUARD_CLKS > 1) ? $clog2(GUARD_CLKS) : 1;

  cmi_frame_parser #(
    .BYTE_TIMEOUT (BYTE_TIMEOUT)
  ) u_parser (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_ena      (rx_ena),
    .rx_data     (rx_data),
    .marker_st   (marker_st),
    .marker_type (marker_type),
    .rx_head     (rx_head),
    .rx_data0    (rx_data0),
    .rx_data1    (rx_data1),
    .rx_data2    (rx_data2),
    .rx_data3    (rx_data3),
    .rx_st       (rx_st),
    .rx_fault    (rx_fault)
  );

  tx_state_e     tx_state;
  pkt_s          pkt;
  logic [5:0]    seq;
  logic [3:0]    idx;
  logic [7:0]    chk_acc;
  logic [GW-1:0] gcnt;
  logic [7:0]    cur_byte;
  logic          own_marker;

  assign own_marker = marker_st && (marker_type == SLOT_ID) && enable;
  assign cur_byte   = pkt_byte(pkt, idx, chk_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state     <= T_IDLE;
      pkt          <= '0;
      seq          <= '0;
      idx          <= '0;
      chk_acc      <= '0;
      gcnt         <= '0;
      tx_data      <= '0;
      tx_enable    <= 1'b0;
      slot_overrun <= 1'b0;
      tx_active    <= 1'b0;
    end else begin
      tx_enable    <= 1'b0;
      slot_overrun <= 1'b0;

      // A marker for us while a packet is in flight is dropped, not queued.
      if (own_marker && tx_state != T_IDLE) slot_overrun <= 1'b1;

      case (tx_state)
        T_IDLE: begin
          if (own_marker) begin
            pkt.head  <= {seq, SLOT_ID};
            pkt.d0    <= data0_self;
            pkt.d1    <= data1_self;
            pkt.d2    <= data2_self;
            pkt.d3    <= data3_self;
            seq       <= seq + 6'd1;
            idx       <= '0;
            chk_acc   <= '0;
            gcnt      <= GW'(1);
            tx_active <= 1'b1;
            // T_LOAD itself costs one clock, so the guard state covers the
            // remaining GUARD_CLKS-1 clocks and the first byte launches
            // exactly GUARD_CLKS clocks after accept.
            tx_state  <= (GUARD_CLKS <= 1) ? T_LOAD : T_GUARD;
          end
        end
        T_GUARD: begin
          if (gcnt == GW'(GUARD_CLKS - 1)) tx_state <= T_LOAD;
          else                             gcnt     <= gcnt + 1'b1;
        end
        T_LOAD: begin
          if (!tx_busy) begin
            tx_enable <= 1'b1;
            tx_data   <= cur_byte;
            if (idx >= 4'd1 && idx <= 4'd9) chk_acc <= chk_acc ^ cur_byte;
            tx_state  <= T_ACK;
          end
        end
        T_ACK: begin
          if (tx_busy) tx_state <= T_DONE;
        end
        T_DONE: begin
          if (!tx_busy) begin
            if (idx == 4'(PKT_LEN - 1)) begin
              tx_active <= 1'b0;
              tx_state  <= T_IDLE;
            end else begin
              idx      <= idx + 4'd1;
              tx_state <= T_LOAD;
            end
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmi_slot_responder.sv
module tb_cmi_slot_responder;
  localparam logic [1:0] SLOT     = 2'b01;
  localparam int         GUARD    = 16;
  localparam int         TMO      = 2048;
  localparam int         BUSY_LEN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        rx_ena = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy = 1'b0;
  logic [15:0] data0_self = 16'hA1B2, data1_self = 16'hC3D4;
  logic [15:0] data2_self = 16'hE5F6, data3_self = 16'h0718;
  logic [7:0]  tx_data;
  logic        tx_enable, marker_st, rx_st, rx_fault, slot_overrun, tx_active;
  logic [1:0]  marker_type;
  logic [7:0]  rx_head;
  logic [15:0] rx_data0, rx_data1, rx_data2, rx_data3;

  cmi_slot_responder #(.SLOT_ID(SLOT), .GUARD_CLKS(GUARD), .BYTE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx_ena(rx_ena), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_enable(tx_enable),
    .data0_self(data0_self), .data1_self(data1_self),
    .data2_self(data2_self), .data3_self(data3_self),
    .marker_st(marker_st), .marker_type(marker_type), .rx_head(rx_head),
    .rx_data0(rx_data0), .rx_data1(rx_data1), .rx_data2(rx_data2), .rx_data3(rx_data3),
    .rx_st(rx_st), .rx_fault(rx_fault), .slot_overrun(slot_overrun), .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (updated at each rising edge) -------
  logic [7:0]  frame[$];
  int          silent = 0;
  logic        e_marker_st = 0, e_rx_st = 0, e_rx_fault = 0, e_overrun = 0;
  logic [1:0]  e_marker_type = 0;
  logic [7:0]  e_head = 0;
  logic [15:0] e_d[4] = '{default: 16'h0};
  logic [5:0]  m_seq = 0;
  logic        m_active = 0;
  logic        last_busy_seen = 0;
  logic [7:0]  txq[11];
  int          cyc = 0, acc_cyc = 0, m_pkt_id = 0;
  int          sent = 0, seen_id = 0;

  always @(posedge clk) begin
    logic       own;
    logic [7:0] x;
    cyc++;
    if (!rst_n) begin
      frame.delete(); silent = 0;
      e_marker_st = 0; e_rx_st = 0; e_rx_fault = 0; e_overrun = 0;
      e_marker_type = 0; e_head = 0; e_d = '{default: 16'h0};
      m_seq = 0; m_active = 0; last_busy_seen = 0;
    end else begin
      own = e_marker_st && (e_marker_type == SLOT) && enable;
      e_overrun = 0;
      if (own && !m_active) begin
        txq[0] = 8'hA5;
        txq[1] = {m_seq, SLOT};
        {txq[2], txq[3], txq[4], txq[5]} = {data0_self, data1_self};
        {txq[6], txq[7], txq[8], txq[9]} = {data2_self, data3_self};
        x = 8'h00;
        for (int i = 1; i <= 9; i++) x ^= txq[i];
        txq[10] = x;
        m_seq = m_seq + 6'd1;
        m_active = 1; last_busy_seen = 0; acc_cyc = cyc; m_pkt_id++;
      end else begin
        if (own) e_overrun = 1;
        // Packet ends one clock after the core goes idle on the last byte.
        if (m_active && sent == 11 && last_busy_seen && !tx_busy) m_active = 0;
        else if (m_active && sent == 11 && tx_busy) last_busy_seen = 1;
      end

      e_marker_st = 0; e_rx_st = 0; e_rx_fault = 0;
      if (rx_ena) begin
        silent = 0;
        if (frame.size() == 0) begin
          if (rx_data == 8'hA5 || rx_data == 8'h5A) frame.push_back(rx_data);
        end else begin
          frame.push_back(rx_data);
          if (frame[0] == 8'hA5 && frame.size() == 11) begin
            x = 8'h00;
            for (int i = 1; i <= 9; i++) x ^= frame[i];
            if (x == frame[10]) begin
              e_rx_st = 1; e_head = frame[1];
              for (int k = 0; k < 4; k++) e_d[k] = {frame[2+2*k], frame[3+2*k]};
            end else e_rx_fault = 1;
            frame.delete();
          end else if (frame[0] == 8'h5A && frame.size() == 3) begin
            if (frame[1] <= 8'h03 && frame[2] == ~frame[1]) begin
              e_marker_st = 1; e_marker_type = frame[1][1:0];
            end else e_rx_fault = 1;
            frame.delete();
          end
        end
      end else if (frame.size() != 0) begin
        silent++;
        if (silent == TMO) begin
          e_rx_fault = 1; frame.delete(); silent = 0;
        end
      end
    end
  end

  // ---------------- compare + byte-core model (falling edge) --------------
  int busy_cnt = 0;
  int n_marker = 0, n_rx_st = 0, n_fault = 0, n_overrun = 0, n_txen = 0;
  logic [7:0] tx_log[11];

  always @(negedge clk) begin
    if (!rst_n) begin
      sent = 0;
    end else begin
      if (m_pkt_id != seen_id) begin seen_id = m_pkt_id; sent = 0; end
      check("marker_st", marker_st, e_marker_st);
      check("marker_type", marker_type, e_marker_type);
      check("rx_st", rx_st, e_rx_st);
      check("rx_fault", rx_fault, e_rx_fault);
      check("rx_head", rx_head, e_head);
      check("rx_data", {rx_data0, rx_data1, rx_data2, rx_data3},
            {e_d[0], e_d[1], e_d[2], e_d[3]});
      check("slot_overrun", slot_overrun, e_overrun);
      check("tx_active", tx_active, m_active);
      if (tx_enable) begin
        check("tx_en_allowed", m_active && sent < 11, 1'b1);
        if (m_active && sent < 11) begin
          check($sformatf("tx_byte%0d", sent), tx_data, txq[sent]);
          if (sent == 0) check("guard_delay", cyc - acc_cyc, GUARD);
          tx_log[sent] = tx_data;
          sent++;
        end
      end
      if (marker_st)    n_marker++;
      if (rx_st)        n_rx_st++;
      if (rx_fault)     n_fault++;
      if (slot_overrun) n_overrun++;
      if (tx_enable)    n_txen++;
    end
    if (tx_enable) begin
      tx_busy = 1; busy_cnt = BUSY_LEN;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 0;
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_ena = 1; rx_data = b;
    @(negedge clk); rx_ena = 0;
    @(negedge clk);
  endtask

  task automatic send_mrk(input logic [7:0] m, input logic [7:0] mc);
    send_byte(8'h5A); send_byte(m); send_byte(mc);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] head, input logic [63:0] d, input logic [7:0] chk_flip);
    logic [7:0] c;
    logic [63:0] dd;
    dd = d;
    c = head;
    for (int i = 7; i >= 0; i--) c ^= dd[i*8 +: 8];
    send_byte(8'hA5); send_byte(head);
    for (int i = 7; i >= 0; i--) send_byte(dd[i*8 +: 8]);
    send_byte(c ^ chk_flip);
    #1;
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!tx_active) break;
      @(negedge clk);
    end
    #1;
    check("tx_done_bound", tx_active, 1'b0);
  endtask

  task automatic answer_own();
    send_mrk(8'h01, 8'hFE);
    wait_cycles(3);
    wait_tx_idle();
  endtask

  int b_txen, b_fault, b_rx, b_mrk, b_ovr;

  initial begin
    #12;
    check("rst_tx_enable", tx_enable, 1'b0);
    check("rst_tx_active", tx_active, 1'b0);
    check("rst_rx_head", rx_head, 8'h00);
    check("rst_rx_data0", rx_data0, 16'h0000);
    @(negedge clk); rst_n = 1;
    wait_cycles(2);

    // 1: own marker -> one answer packet, then the next HEAD
    b_mrk = n_marker; b_txen = n_txen;
    answer_own();
    check("t1_marker_cnt", n_marker - b_mrk, 1);
    check("t1_tx_bytes", n_txen - b_txen, 11);
    check("t1_byte0", tx_log[0], 8'hA5);
    check("t1_head", tx_log[1], 8'h01);
    check("t1_d0h", tx_log[2], 8'hA1);
    check("t1_chk", tx_log[10], 8'h09);
    answer_own();
    check("t1_head_next", tx_log[1], 8'h05);

    // 2: good packet, then a corrupted one
    b_rx = n_rx_st; b_fault = n_fault;
    send_pkt(8'h07, 64'h12345678_9ABCDEF0, 8'h00);
    check("t2_rx_st_cnt", n_rx_st - b_rx, 1);
    check("t2_rx_data0", rx_data0, 16'h1234);
    check("t2_rx_data3", rx_data3, 16'hDEF0);
    check("t2_rx_head", rx_head, 8'h07);
    send_pkt(8'h08, 64'h11112222_33334444, 8'h01);
    check("t2_bad_fault", n_fault - b_fault, 1);
    check("t2_bad_head_kept", rx_head, 8'h07);
    check("t2_bad_data_kept", rx_data0, 16'h1234);

    // 3: other-slot marker, corrupted marker
    b_txen = n_txen; b_mrk = n_marker; b_fault = n_fault;
    send_mrk(8'h02, 8'hFD);
    check("t3_marker_type", marker_type, 2'b10);
    wait_cycles(40);
    check("t3_no_tx", n_txen - b_txen, 0);
    send_mrk(8'h01, 8'h00);
    wait_cycles(2);
    check("t3_bad_mrk_fault", n_fault - b_fault, 1);
    check("t3_bad_mrk_no_st", n_marker - b_mrk, 1);

    // 4: stalled packet times out, next packet still decodes
    b_fault = n_fault;
    send_byte(8'hA5); send_byte(8'h07);
    wait_cycles(TMO - 10);
    check("t4_not_yet", n_fault - b_fault, 0);
    wait_cycles(20);
    check("t4_timeout", n_fault - b_fault, 1);
    send_pkt(8'h2C, 64'h0102030405060708, 8'h00);
    check("t4_recover_head", rx_head, 8'h2C);

    // 5: sequence wrap over 64 answers (seq starts at 2 here)
    for (int i = 0; i < 64; i++) begin
      answer_own();
      if (i == 61) check("t5_head_seq63", tx_log[1], 8'hFD);
      if (i == 62) check("t5_head_seq0", tx_log[1], 8'h01);
    end
    // own marker mid-TX with concurrent RX traffic
    b_txen = n_txen; b_ovr = n_overrun;
    send_mrk(8'h01, 8'hFE);
    wait_cycles(3);
    send_pkt(8'h3C, 64'hCAFEBABE_0BADF00D, 8'h00);
    send_mrk(8'h01, 8'hFE);
    wait_tx_idle();
    check("t5_overrun", n_overrun - b_ovr, 1);
    check("t5_one_packet", n_txen - b_txen, 11);
    check("t5_head_after_wrap", tx_log[1], 8'h09);
    check("t5_rx_during_tx", rx_head, 8'h3C);

    // enable low: no answer; enable dropping mid-packet: packet completes
    enable = 0; b_txen = n_txen;
    send_mrk(8'h01, 8'hFE);
    wait_cycles(40);
    check("en0_no_tx", n_txen - b_txen, 0);
    enable = 1;
    send_mrk(8'h01, 8'hFE);
    wait_cycles(30);
    enable = 0;
    wait_tx_idle();
    check("en_fall_completes", n_txen - b_txen, 11);
    check("en_fall_head", tx_log[1], 8'h0D);
    enable = 1;

    // 6: reset during the answer
    b_txen = n_txen;
    send_mrk(8'h01, 8'hFE);
    for (int i = 0; i < 1000; i++) begin
      if (n_txen - b_txen >= 5) break;
      @(negedge clk);
    end
    check("t6_reached_byte5", n_txen - b_txen, 5);
    @(posedge clk); #2 rst_n = 0;
    #1;
    check("t6_rst_tx_enable", tx_enable, 1'b0);
    check("t6_rst_tx_active", tx_active, 1'b0);
    check("t6_rst_rx_head", rx_head, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1;
    b_txen = n_txen;
    wait_cycles(10);
    check("t6_quiet_after_rst", n_txen - b_txen, 0);
    answer_own();
    check("t6_seq_restart", tx_log[1], 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
